// File: rtl/alu_pkg.sv
// alu_pkg: shared command type, opcodes, issuer states and default widths for the ALU feeder
package alu_pkg;
  localparam int ALU_DATA_W = 8;
  localparam int ALU_SEL_W  = 2;
  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 2'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB = 2'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_AND = 2'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_OR  = 2'd3;
  typedef struct packed {
    logic [ALU_SEL_W-1:0]  sel;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
  } alu_cmd_t;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} issuer_state_e;
endpackage

// File: rtl/cmd_sync_fifo.sv
// cmd_sync_fifo: synchronous FIFO of ALU commands with wrap-bit pointers and synchronous flush
module cmd_sync_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  alu_cmd_t                 wdata,
  output alu_cmd_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  alu_cmd_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = wr_ptr == rd_ptr;
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  // storage array, written on accepted pushes only
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  // pointer update; flush wins over push and pop
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
    end
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands and issues them as valid pulses with a programmable gap; ALU_CMD_STATS_EN adds issue/drop counters
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SEL_W  = ALU_SEL_W,
  parameter int DEPTH  = 8,
  parameter int GAP_W  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  input  logic                   issue_en,
  input  logic [GAP_W-1:0]       issue_gap,
  input  logic                   flush,
  output logic [SEL_W-1:0]       sel,
  output logic [DATA_W-1:0]      a,
  output logic [DATA_W-1:0]      b,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
`ifdef ALU_CMD_STATS_EN
  ,
  output logic [15:0]            issued_cnt,
  output logic [15:0]            drop_cnt
`endif
);
  issuer_state_e state;
  alu_cmd_t wdata, head;
  logic full, empty, push, pop;
  logic [GAP_W-1:0] gcnt;
  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = issue_en && !empty && state != GAP && !flush;
  assign wdata    = '{sel: in_sel, a: in_a, b: in_b};
  cmd_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // issue FSM: pop straight into the output registers, then optionally hold off for the sampled gap
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      gcnt  <= '0;
      valid <= 1'b0;
      sel   <= '0;
      a     <= '0;
      b     <= '0;
    end else if (flush) begin
      state <= IDLE;
      gcnt  <= '0;
      valid <= 1'b0;
    end else if (pop) begin
      valid <= 1'b1;
      sel   <= head.sel;
      a     <= head.a;
      b     <= head.b;
      gcnt  <= issue_gap;
      state <= (issue_gap != '0) ? GAP : (count > 1 && issue_en) ? ISSUE : IDLE;
    end else begin
      valid <= 1'b0;
      gcnt  <= (state == GAP) ? gcnt - 1'b1 : '0;
      state <= (state == GAP && gcnt > 1) ? GAP : IDLE;
    end
`ifdef ALU_CMD_STATS_EN
  // saturating issue and drop counters, cleared only by reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      issued_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      issued_cnt <= (valid && issued_cnt != 16'hFFFF) ? issued_cnt + 1'b1 : issued_cnt;
      drop_cnt   <= (in_valid && (!in_ready || flush) && drop_cnt != 16'hFFFF) ? drop_cnt + 1'b1 : drop_cnt;
    end
`endif
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: scoreboard bench for the ALU command issuer
module tb_alu_cmd_issuer;
  import alu_pkg::*;
  logic clk = 0, reset = 0, in_valid = 0, issue_en = 0, flush = 0;
  logic [1:0] in_sel = 0;
  logic [7:0] in_a = 0, in_b = 0;
  logic [3:0] issue_gap = 0;
  logic in_ready, valid;
  logic [1:0] sel;
  logic [7:0] a, b;
  logic [3:0] count;
`ifdef ALU_CMD_STATS_EN
  logic [15:0] issued_cnt, drop_cnt;
`endif
  int checks = 0, errors = 0, cyc = 0;
  alu_cmd_t exp_q[$];
  alu_cmd_t e;
  int pulse_q[$];

  alu_cmd_issuer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_a(in_a), .in_b(in_b), .issue_en(issue_en),
    .issue_gap(issue_gap), .flush(flush), .sel(sel), .a(a), .b(b),
    .valid(valid), .count(count)
`ifdef ALU_CMD_STATS_EN
    , .issued_cnt(issued_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // expected commands enter the scoreboard on each accepted push
  always @(posedge clk) begin
    cyc++;
    if (!reset || flush) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back('{sel: in_sel, a: in_a, b: in_b});
  end

  // every valid pulse must match the oldest outstanding command
  always @(negedge clk)
    if (reset && valid) begin
      pulse_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_issue: unexpected pulse sel=%0d a=%h b=%h, none queued", sel, a, b);
      end else begin
        e = exp_q.pop_front();
        if ({sel, a, b} !== e) begin
          errors++;
          $display("FAIL sb_issue: got sel=%0d a=%h b=%h, need sel=%0d a=%h b=%h", sel, a, b, e.sel, e.a, e.b);
        end
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] s, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1;
    in_sel = s;
    in_a = x;
    in_b = y;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (valid !== 0 || count !== 0 || in_ready !== 1 || {sel, a, b} !== 18'd0) begin
      errors++;
      $display("FAIL reset: valid=%b count=%0d in_ready=%b sel=%0d a=%h b=%h, need 0 0 1 0 00 00", valid, count, in_ready, sel, a, b);
    end
    @(posedge clk);
    #1 reset = 1;
    issue_en = 1;
  endtask

  task automatic test_basic();
    issue_gap = 0;
    drive(ALU_ADD, 8'h05, 8'h03);
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    checks++;
    if (valid !== 0) begin errors++; $display("FAIL basic_early: valid=%b, need 0", valid); end
    @(negedge clk);
    checks++;
    if (valid !== 1 || sel !== 2'd0 || a !== 8'h05 || b !== 8'h03) begin
      errors++;
      $display("FAIL basic_pulse: valid=%b sel=%0d a=%h b=%h, need 1 0 05 03", valid, sel, a, b);
    end
    @(negedge clk);
    checks++;
    if (valid !== 0 || count !== 0 || a !== 8'h05) begin
      errors++;
      $display("FAIL basic_after: valid=%b count=%0d a=%h, need 0 0 05", valid, count, a);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    pulse_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 8'(8'h10 + i), 8'(8'h20 + i));
      tick();
    end
    in_valid = 0;
    repeat (8) tick();
    checks++;
    if (pulse_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d, need 4", pulse_q.size());
    end else
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (pulse_q[i] - pulse_q[i-1] != 1) begin
          errors++;
          $display("FAIL b2b_spacing: gap=%0d cycles, need 1", pulse_q[i] - pulse_q[i-1]);
        end
      end
  endtask

  task automatic test_gap();
    pulse_q.delete();
    issue_gap = 3;
    for (int i = 0; i < 3; i++) begin
      drive(ALU_SUB, 8'(8'h40 + i), 8'(8'hC0 - i));
      tick();
    end
    in_valid = 0;
    repeat (16) tick();
    checks++;
    if (pulse_q.size() != 3) begin
      errors++;
      $display("FAIL gap_count: pulses=%0d, need 3", pulse_q.size());
    end else
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (pulse_q[i] - pulse_q[i-1] != 4) begin
          errors++;
          $display("FAIL gap_spacing: gap=%0d cycles, need 4", pulse_q[i] - pulse_q[i-1]);
        end
      end
    issue_gap = 0;
  endtask

  task automatic test_full();
    issue_en = 0;
    for (int i = 0; i < 8; i++) begin
      drive(ALU_AND, 8'(i), 8'(8'hF0 | i));
      tick();
    end
    drive(ALU_OR, 8'h99, 8'h66);
    tick();
    @(negedge clk);
    checks++;
    if (in_ready !== 0 || count !== 8 || valid !== 0) begin
      errors++;
      $display("FAIL full_hold: in_ready=%b count=%0d valid=%b, need 0 8 0", in_ready, count, valid);
    end
    @(posedge clk);
    #1 issue_en = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 0) begin errors++; $display("FAIL full_no_passthru: in_ready=%b, need 0", in_ready); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1 || count !== 7 || valid !== 1) begin
      errors++;
      $display("FAIL full_first_pop: in_ready=%b count=%0d valid=%b, need 1 7 1", in_ready, count, valid);
    end
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    checks++;
    if (count !== 7) begin errors++; $display("FAIL full_push_pop: count=%0d, need 7", count); end
    repeat (12) tick();
    checks++;
    if (count !== 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_drain: count=%0d outstanding=%0d, need 0 0", count, exp_q.size());
    end
  endtask

  task automatic test_flush();
    issue_en = 0;
    issue_gap = 3;
    for (int i = 0; i < 6; i++) begin
      drive(ALU_ADD, 8'(8'h60 + i), 8'h01);
      tick();
    end
    in_valid = 0;
    issue_en = 1;
    tick();
    flush = 1;
    drive(ALU_SUB, 8'h77, 8'h77);
    @(negedge clk);
    checks++;
    if (count !== 5 || valid !== 1) begin
      errors++;
      $display("FAIL flush_pre: count=%0d valid=%b, need 5 1", count, valid);
    end
    tick();
    flush = 0;
    in_valid = 0;
    issue_gap = 0;
    @(negedge clk);
    checks++;
    if (count !== 0 || valid !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL flush_clear: count=%0d valid=%b in_ready=%b, need 0 0 1", count, valid, in_ready);
    end
    pulse_q.delete();
    repeat (10) tick();
    checks++;
    if (pulse_q.size() != 0 || count !== 0) begin
      errors++;
      $display("FAIL flush_dropped: pulses=%0d count=%0d, need 0 0", pulse_q.size(), count);
    end
    drive(ALU_OR, 8'h3C, 8'hC3);
    tick();
    in_valid = 0;
    repeat (3) tick();
    checks++;
    if (pulse_q.size() != 1) begin
      errors++;
      $display("FAIL flush_resume: pulses=%0d, need 1", pulse_q.size());
    end
  endtask

  task automatic test_async_reset();
    int n;
    for (int i = 0; i < 4; i++) begin
      drive(ALU_OR, 8'(8'hA0 + i), 8'h5F);
      tick();
    end
    in_valid = 0;
    n = 0;
    @(negedge clk);
    while (!valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!valid) begin
      errors++;
      $display("FAIL areset_wait: valid=%b after %0d cycles, need 1", valid, n);
    end
    #2 reset = 0;
    #1;
    checks++;
    if (valid !== 0 || count !== 0 || {sel, a, b} !== 18'd0 || in_ready !== 1) begin
      errors++;
      $display("FAIL areset_clear: valid=%b count=%0d sel=%0d a=%h b=%h in_ready=%b, need 0 0 0 00 00 1", valid, count, sel, a, b, in_ready);
    end
    exp_q.delete();
    pulse_q.delete();
    @(posedge clk);
    #1 reset = 1;
    repeat (4) tick();
    checks++;
    if (pulse_q.size() != 0 || count !== 0) begin
      errors++;
      $display("FAIL areset_after: pulses=%0d count=%0d, need 0 0", pulse_q.size(), count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gap();
    test_full();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Upstream feeder stage for the ALU. Accepts operation commands (sel, a, b) over a valid/ready handshake and buffers them in a small synchronous FIFO. Issues them to the ALU input port as single-cycle valid pulses, with a programmable minimum gap between issues. Supports issue enable/pause and synchronous flush.

Parameters:
- DATA_W, 8, operand width of a and b.
- SEL_W, 2, ALU opcode width.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- GAP_W, 4, width of the issue_gap input.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  command offered.
- in_ready  out  1  command accepted when in_valid && in_ready.
- in_sel  in  SEL_W  opcode.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- issue_en  in  1  1 = issuing allowed; 0 = pause after the current cycle.
- issue_gap  in  GAP_W  idle cycles forced between consecutive issues.
- flush  in  1  synchronous clear of FIFO and issue state.
- sel  out  SEL_W  to ALU sel.
- a  out  DATA_W  to ALU a.
- b  out  DATA_W  to ALU b.
- valid  out  1  to ALU valid; one-cycle pulse per command.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, async):
  - FIFO pointers, count, gap counter, sel/a/b and valid all cleared to 0.
  - FSM goes to IDLE.
  - in_ready = !full, so it reads 1 while in reset and after release.
- FIFO:
  - Pointers carry an extra wrap bit; full/empty are derived from the pointers.
  - in_ready depends only on full; there is no pass-through when full, even if a pop occurs in the same cycle.
  - There is no bypass when empty; a command always spends at least one cycle in the FIFO.
  - Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged.
- FSM states IDLE, ISSUE, GAP:
  - IDLE → ISSUE when !empty && issue_en.
  - ISSUE (one cycle): pop the head entry; register it onto sel/a/b; valid=1.
    - If issue_gap != 0: load the gap counter with issue_gap and go to GAP.
    - Else if !empty-after-pop && issue_en: stay in ISSUE (back-to-back issue, one per cycle).
    - Else go to IDLE.
  - GAP: gap counter decrements each cycle; at 1 → IDLE. issue_gap is sampled only on entry, so changes during GAP have no effect.
- Outputs:
  - valid is registered and is 1 only in the cycle after an ISSUE decision.
  - sel/a/b hold their last issued value while valid=0.
- Latency: push at edge N into an empty FIFO with issue_en=1 gives valid=1 in the cycle following edge N+1. Throughput is one command every issue_gap+1 cycles.
- issue_en=0 in IDLE blocks issue. issue_en=0 while in ISSUE completes the current pop and then goes to IDLE.
- flush has priority over push and pop:
  - Next edge: pointers and count go to 0, FSM to IDLE, gap counter to 0, valid to 0.
  - A push presented in the flush cycle is dropped, even though in_ready was 1.
- Reset mid-operation: immediate clear; no partial valid pulse survives.
- issue_gap sampled as unsigned; 0 means no gap.

Optional Feature:
- Macro ALU_CMD_STATS_EN.
- Defined: adds 16-bit outputs issued_cnt and drop_cnt.
  - issued_cnt increments on every valid pulse.
  - drop_cnt increments on each in_valid && !in_ready cycle and on each push dropped by flush.
  - Both saturate at 16'hFFFF; both clear on reset only, not on flush.
- Undefined: these ports and all counter logic are absent.

Decomposition:
- Package alu_pkg holds:
  - typedef alu_cmd_t (packed struct: sel, a, b).
  - Opcode localparams (ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3).
  - FSM state enum issuer_state_e.
  - Shared DATA_W/SEL_W defaults.
- Sub-module cmd_sync_fifo: generic sync FIFO of alu_cmd_t with push, pop, flush, full, empty and count. The issuer instantiates it and adds the FSM, gap counter and output registers.

Test Plan:
- Basic issue: reset, then push {sel=0,a=8'h05,b=8'h03}, issue_gap=0 → one valid pulse two edges after the push, sel=0 a=05 b=03; count returns to 0.
- Back-to-back: push 4 commands on consecutive cycles, gap=0 → 4 consecutive valid cycles in push order.
- Gap spacing: gap=3, push 3 commands → valid pulses exactly 4 cycles apart.
- Full boundary: issue_en=0, push 9 commands → first 8 accepted; in_ready=0 with count=8; 9th held. Then issue_en=1 → 9th accepted the cycle after the first pop.
- Flush during GAP with push: count=5, flush=1 together with in_valid=1 → next cycle count=0, valid=0, state IDLE; the pushed command is never issued.
- Async reset: assert reset mid-stream while valid=1 → valid, count and sel/a/b go to 0 immediately without waiting for a clock edge; in_ready=1.
